imp_cmd_exec: RTL and testbench

Command executor at the consuming end of the command-memory interface. Accepts one pulse-train command per `DATA_WR` strobe and holds it until system time reaches its start time. It then generates the blanking, impulse and frequency-sweep sequence. On completion it raises `REQ_COMM` so the command-memory writer erases the executed entry and supplies the next-nearest command.

---
 rtl/imp_cmd_exec_if.sv | 34 +++
 rtl/imp_cmd_exec.sv | 143 ++++++++++++++
 tb/tb_imp_cmd_exec.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/imp_cmd_exec_if.sv
// imp_cmd_exec_if: command fields from the command-memory writer and executor status back to it
interface imp_cmd_exec_if;
  logic [63:0] TIME;
  logic        DATA_WR;
  logic [47:0] FREQ;
  logic [47:0] FREQ_STEP;
  logic [31:0] FREQ_RATE;
  logic [63:0] TIME_START;
  logic [15:0] N_impulse;
  logic [1:0]  TYPE_impulse;
  logic [31:0] Interval_Ti;
  logic [31:0] Interval_Tp;
  logic [31:0] Tblank1;
  logic [31:0] Tblank2;
  logic        REQ_COMM;
  logic        IMP;
  logic        BLANK;
  logic [47:0] NCO_FREQ;
  logic        FREQ_WR;
  logic        BUSY;
  logic [15:0] IMP_CNT;
  logic        LATE;
  logic        CMD_DROP;
  modport master (
    output TIME, DATA_WR, FREQ, FREQ_STEP, FREQ_RATE, TIME_START, N_impulse, TYPE_impulse,
           Interval_Ti, Interval_Tp, Tblank1, Tblank2,
    input  REQ_COMM, IMP, BLANK, NCO_FREQ, FREQ_WR, BUSY, IMP_CNT, LATE, CMD_DROP
  );
  modport slave (
    input  TIME, DATA_WR, FREQ, FREQ_STEP, FREQ_RATE, TIME_START, N_impulse, TYPE_impulse,
           Interval_Ti, Interval_Tp, Tblank1, Tblank2,
    output REQ_COMM, IMP, BLANK, NCO_FREQ, FREQ_WR, BUSY, IMP_CNT, LATE, CMD_DROP
  );
endinterface

// File: rtl/imp_cmd_exec.sv
// imp_cmd_exec: holds one pulse-train command until its start time, then plays blank/impulse/sweep and requests the next
module imp_cmd_exec #(
  parameter int REQ_LEN = 4
) (
  input logic           CLK,
  input logic           rst,
  imp_cmd_exec_if.slave bus
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARMED  = 3'd1;
  localparam logic [2:0] S_BLANK1 = 3'd2;
  localparam logic [2:0] S_PULSE  = 3'd3;
  localparam logic [2:0] S_GAP    = 3'd4;
  localparam logic [2:0] S_BLANK2 = 3'd5;
  localparam logic [2:0] S_REQ    = 3'd6;
  logic [2:0]  state_q, state_d;
  logic [31:0] cnt_q, cnt_d, rate_q, rate_d, len_d, gap_len;
  logic [47:0] nco_q, nco_d, freq_q, step_q;
  logic [31:0] frate_q, ti_q, tp_q, tb1_q, tb2_q;
  logic [63:0] ts_q;
  logic [15:0] n_q, imp_cnt_q, imp_cnt_d;
  logic [1:0]  type_q;
  logic        fwr_q, fwr_d, late_q, first_q, drop_q;
  logic        busy, go, done, accept, latch, pulse_start, pulse_end, sweep, reload;
  logic [2:0]  after_train, after_blank1, after_arm, after_gap, after_pulse;
  assign busy         = state_q != S_IDLE && state_q != S_ARMED;
  assign go           = state_q == S_ARMED && bus.TIME >= ts_q;
  assign done         = cnt_q == 32'd0;
  assign accept       = state_q == S_IDLE || (state_q == S_ARMED && !go);
  assign latch        = bus.DATA_WR && accept;
  assign gap_len      = tp_q > ti_q ? tp_q - ti_q : 32'd0;
  assign sweep        = (type_q == 2'd1 || type_q == 2'd2) && frate_q != 32'd0;
  assign after_train  = tb2_q != 32'd0 ? S_BLANK2 : S_REQ;
  assign after_blank1 = n_q != 16'd0 ? S_PULSE : after_train;
  assign after_arm    = tb1_q != 32'd0 ? S_BLANK1 : after_blank1;
  assign after_gap    = imp_cnt_q == n_q ? after_train : S_PULSE;
  assign after_pulse  = gap_len != 32'd0 ? S_GAP : ((imp_cnt_q + 16'd1) == n_q ? after_train : S_PULSE);
  assign pulse_start  = state_d == S_PULSE && (state_q != S_PULSE || done);
  assign pulse_end    = state_q == S_PULSE && done;
  assign reload       = pulse_start && sweep && type_q == 2'd1 && (state_q == S_PULSE || state_q == S_GAP);
  assign imp_cnt_d    = go ? 16'd0 : pulse_end ? imp_cnt_q + 16'd1 : imp_cnt_q;
  assign cnt_d        = busy && !done ? cnt_q - 32'd1 : len_d;
  // Next state; empty states are skipped here so no idle cycle appears between stages
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = bus.DATA_WR ? S_ARMED : S_IDLE;
      S_ARMED:  state_d = go ? after_arm : S_ARMED;
      S_BLANK1: state_d = done ? after_blank1 : S_BLANK1;
      S_PULSE:  state_d = done ? after_pulse : S_PULSE;
      S_GAP:    state_d = done ? after_gap : S_GAP;
      S_BLANK2: state_d = done ? S_REQ : S_BLANK2;
      S_REQ:    state_d = done ? S_IDLE : S_REQ;
      default:  state_d = S_IDLE;
    endcase
  end
  // Down-counter reload value for the state being entered (duration minus one, exit at zero)
  always_comb begin
    len_d = 32'd0;
    case (state_d)
      S_BLANK1: len_d = tb1_q - 32'd1;
      S_PULSE:  len_d = ti_q == 32'd0 ? 32'd0 : ti_q - 32'd1;
      S_GAP:    len_d = gap_len - 32'd1;
      S_BLANK2: len_d = tb2_q - 32'd1;
      S_REQ:    len_d = 32'(REQ_LEN - 1);
      default:  len_d = 32'd0;
    endcase
  end
  // Frequency word: load on start and on type-1 impulse restarts, step every FREQ_RATE pulse cycles
  always_comb begin
    nco_d  = nco_q;
    rate_d = rate_q;
    fwr_d  = 1'b0;
    if (go || reload) begin
      nco_d  = freq_q;
      rate_d = 32'd0;
      fwr_d  = 1'b1;
    end else if (state_q == S_PULSE && sweep) begin
      rate_d = rate_q == frate_q - 32'd1 ? 32'd0 : rate_q + 32'd1;
      nco_d  = rate_q == frate_q - 32'd1 ? nco_q + step_q : nco_q;
      fwr_d  = rate_q == frate_q - 32'd1;
    end
  end
  // Sequencer, counters and status flags
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 32'd0;
      rate_q    <= 32'd0;
      nco_q     <= 48'd0;
      fwr_q     <= 1'b0;
      imp_cnt_q <= 16'd0;
      late_q    <= 1'b0;
      first_q   <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rate_q    <= rate_d;
      nco_q     <= nco_d;
      fwr_q     <= fwr_d;
      imp_cnt_q <= imp_cnt_d;
      late_q    <= late_q | (go & first_q);
      first_q   <= latch;
      drop_q    <= bus.DATA_WR & ~accept;
    end
  end
  // Command latch; a write while ARMED replaces the pending command
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      freq_q  <= 48'd0;
      step_q  <= 48'd0;
      frate_q <= 32'd0;
      ts_q    <= 64'd0;
      n_q     <= 16'd0;
      type_q  <= 2'd0;
      ti_q    <= 32'd0;
      tp_q    <= 32'd0;
      tb1_q   <= 32'd0;
      tb2_q   <= 32'd0;
    end else if (latch) begin
      freq_q  <= bus.FREQ;
      step_q  <= bus.FREQ_STEP;
      frate_q <= bus.FREQ_RATE;
      ts_q    <= bus.TIME_START;
      n_q     <= bus.N_impulse;
      type_q  <= bus.TYPE_impulse;
      ti_q    <= bus.Interval_Ti;
      tp_q    <= bus.Interval_Tp;
      tb1_q   <= bus.Tblank1;
      tb2_q   <= bus.Tblank2;
    end
  end
  assign bus.REQ_COMM = state_q == S_REQ;
  assign bus.IMP      = state_q == S_PULSE;
  assign bus.BLANK    = state_q == S_BLANK1 || state_q == S_BLANK2;
  assign bus.BUSY     = busy;
  assign bus.NCO_FREQ = nco_q;
  assign bus.FREQ_WR  = fwr_q;
  assign bus.IMP_CNT  = imp_cnt_q;
  assign bus.LATE     = late_q;
  assign bus.CMD_DROP = drop_q;
endmodule

// File: tb/tb_imp_cmd_exec.sv
// tb_imp_cmd_exec: directed checks of timing, sweep, late, replace/drop, degenerate and reset behaviour
module tb_imp_cmd_exec;
  logic clk = 1'b0;
  logic rst = 1'b1;
  imp_cmd_exec_if bus();
  imp_cmd_exec #(.REQ_LEN(4)) dut (.CLK(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc, blank_first, blank_n, imp_hi, n_rise, req_first, req_n, fwr_n, drop_first, drop_n;
  int rise [8];
  logic imp_prev;
  logic [63:0] t0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    bus.TIME = bus.TIME + 64'd1;
    bus.DATA_WR = 1'b0;
    if (bus.BLANK) begin
      if (blank_first < 0) blank_first = cyc;
      blank_n++;
    end
    if (bus.IMP && !imp_prev) begin
      if (n_rise < 8) rise[n_rise] = cyc;
      n_rise++;
    end
    imp_prev = bus.IMP;
    if (bus.IMP) imp_hi++;
    if (bus.REQ_COMM) begin
      if (req_first < 0) req_first = cyc;
      req_n++;
    end
    if (bus.FREQ_WR) fwr_n++;
    if (bus.CMD_DROP) begin
      if (drop_first < 0) drop_first = cyc;
      drop_n++;
    end
  endtask
  task automatic run(input int n);
    repeat (n) tick();
  endtask
  task automatic start();
    cyc = 0;
    blank_first = -1; blank_n = 0; imp_hi = 0; n_rise = 0;
    req_first = -1; req_n = 0; fwr_n = 0; drop_first = -1; drop_n = 0;
    imp_prev = bus.IMP;
    foreach (rise[i]) rise[i] = -1;
    t0 = bus.TIME;
  endtask
  task automatic load(input logic [63:0] ts, input logic [47:0] f, input logic [47:0] st,
                      input logic [31:0] rate, input logic [15:0] n, input logic [1:0] typ,
                      input logic [31:0] ti, input logic [31:0] tp, input logic [31:0] b1,
                      input logic [31:0] b2);
    bus.TIME_START = ts; bus.FREQ = f; bus.FREQ_STEP = st; bus.FREQ_RATE = rate;
    bus.N_impulse = n; bus.TYPE_impulse = typ; bus.Interval_Ti = ti; bus.Interval_Tp = tp;
    bus.Tblank1 = b1; bus.Tblank2 = b2; bus.DATA_WR = 1'b1;
  endtask
  initial begin
    bus.TIME = 64'd1000; bus.DATA_WR = 1'b0;
    load(64'd0, 48'd0, 48'd0, 32'd0, 16'd0, 2'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    bus.DATA_WR = 1'b0;
    start();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_imp", bus.IMP, 0);
    chk("rst_blank", bus.BLANK, 0);
    chk("rst_req", bus.REQ_COMM, 0);
    chk("rst_busy", bus.BUSY, 0);
    chk("rst_nco", bus.NCO_FREQ, 0);
    chk("rst_fwr", bus.FREQ_WR, 0);
    chk("rst_impcnt", bus.IMP_CNT, 0);
    chk("rst_late", bus.LATE, 0);
    chk("rst_drop", bus.CMD_DROP, 0);
    rst = 1'b0;
    run(3);
    start();
    load(t0 + 64'd100, 48'd5000, 48'd0, 32'd0, 16'd3, 2'd0, 32'd5, 32'd20, 32'd10, 32'd8);
    run(200);
    chk("basic_blank_first", blank_first, 101);
    chk("basic_blank_cycles", blank_n, 18);
    chk("basic_rises", n_rise, 3);
    chk("basic_rise0", rise[0], 111);
    chk("basic_rise1", rise[1], 131);
    chk("basic_rise2", rise[2], 151);
    chk("basic_imp_cycles", imp_hi, 15);
    chk("basic_req_first", req_first, 179);
    chk("basic_req_len", req_n, 4);
    chk("basic_impcnt", bus.IMP_CNT, 3);
    chk("basic_late", bus.LATE, 0);
    chk("basic_nco", bus.NCO_FREQ, 5000);
    chk("basic_fwr", fwr_n, 1);
    chk("basic_busy_end", bus.BUSY, 0);
    start();
    load(t0 + 64'd5, 48'd1000, 48'd10, 32'd2, 16'd2, 2'd2, 32'd4, 32'd8, 32'd2, 32'd2);
    run(40);
    chk("sweep2_nco", bus.NCO_FREQ, 1040);
    chk("sweep2_fwr", fwr_n, 5);
    chk("sweep2_impcnt", bus.IMP_CNT, 2);
    chk("sweep2_late", bus.LATE, 0);
    start();
    load(t0 + 64'd5, 48'd1000, 48'd10, 32'd2, 16'd2, 2'd1, 32'd4, 32'd8, 32'd2, 32'd2);
    run(40);
    chk("sweep1_nco", bus.NCO_FREQ, 1020);
    chk("sweep1_fwr", fwr_n, 6);
    chk("sweep1_req_len", req_n, 4);
    start();
    load(t0 - 64'd5, 48'd7, 48'd0, 32'd0, 16'd1, 2'd0, 32'd1, 32'd1, 32'd1, 32'd0);
    run(20);
    chk("late_blank_first", blank_first, 2);
    chk("late_flag", bus.LATE, 1);
    chk("late_req_first", req_first, 4);
    start();
    load(t0 + 64'd50, 48'd300, 48'd0, 32'd0, 16'd2, 2'd0, 32'd3, 32'd6, 32'd3, 32'd2);
    run(2);
    load(t0 + 64'd20, 48'd300, 48'd0, 32'd0, 16'd2, 2'd0, 32'd3, 32'd6, 32'd3, 32'd2);
    run(23);
    load(t0 + 64'd5, 48'd999, 48'd0, 32'd0, 16'd5, 2'd0, 32'd9, 32'd9, 32'd9, 32'd9);
    run(35);
    chk("repl_blank_first", blank_first, 21);
    chk("repl_rise0", rise[0], 24);
    chk("repl_rise1", rise[1], 30);
    chk("repl_rises", n_rise, 2);
    chk("repl_imp_cycles", imp_hi, 6);
    chk("drop_count", drop_n, 1);
    chk("drop_cycle", drop_first, 26);
    chk("repl_req_first", req_first, 38);
    chk("repl_impcnt", bus.IMP_CNT, 2);
    chk("repl_nco", bus.NCO_FREQ, 300);
    start();
    load(t0 + 64'd10, 48'd50, 48'd0, 32'd0, 16'd0, 2'd0, 32'd5, 32'd20, 32'd0, 32'd0);
    run(30);
    chk("degen_req_first", req_first, 11);
    chk("degen_rises", n_rise, 0);
    chk("degen_blank", blank_n, 0);
    chk("degen_req_len", req_n, 4);
    start();
    load(t0 + 64'd5, 48'd77, 48'd0, 32'd0, 16'd3, 2'd0, 32'd2, 32'd10, 32'd2, 32'd2);
    run(12);
    chk("midrst_busy_before", bus.BUSY, 1);
    chk("midrst_impcnt_before", bus.IMP_CNT, 1);
    rst = 1'b1;
    #2;
    chk("midrst_imp", bus.IMP, 0);
    chk("midrst_blank", bus.BLANK, 0);
    chk("midrst_busy", bus.BUSY, 0);
    chk("midrst_nco", bus.NCO_FREQ, 0);
    chk("midrst_impcnt", bus.IMP_CNT, 0);
    chk("midrst_late", bus.LATE, 0);
    chk("midrst_req", bus.REQ_COMM, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    start();
    run(60);
    chk("midrst_no_req", req_n, 0);
    chk("midrst_no_imp", n_rise, 0);
    chk("midrst_idle", bus.BUSY, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
